// File: rtl/sprite_attr_ram.sv
// Sprite attribute RAM: 32 bytes in two mapped windows, video-side 1-cycle reads,
// and CPU writes buffered in a 2-entry FIFO that drains only when rd_en is low.
// Optional build macro: SPRITE_RAM_BYPASS_EN (reads see the newest pending write).
module sprite_attr_ram (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic [15:0] sprite_RAM_addr,
    output logic [7:0]  sprite_RAM_din,
    output logic        addr_err,
    output logic [7:0]  err_count,
    input  logic        cpu_wr_valid,
    output logic        cpu_wr_ready,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din
);

    // {hit, index}: A window -> 0..15, B window -> 16..31
    function automatic logic [5:0] map_addr(input logic [15:0] a);
        if (a[15:4] == 12'h4FF)      return {2'b10, a[3:0]};
        else if (a[15:4] == 12'h506) return {2'b11, a[3:0]};
        else                         return 6'd0;
    endfunction

    logic [31:0][7:0] mem;
    logic [1:0][15:0] f_addr;
    logic [1:0][7:0]  f_data;
    logic             rd_ptr, wr_ptr;
    logic [1:0]       count;

    logic       push, pop;
    logic [5:0] rd_map, dr_map;
    logic [7:0] rd_data;

    assign cpu_wr_ready = (count != 2'd2);
    assign push   = cpu_wr_valid && cpu_wr_ready;
    assign pop    = !rd_en && (count != 2'd0);
    assign rd_map = map_addr(sprite_RAM_addr);
    assign dr_map = map_addr(f_addr[rd_ptr]);

    always_comb begin
        rd_data = mem[rd_map[4:0]];
`ifdef SPRITE_RAM_BYPASS_EN
        // Older entry first so the newest match overrides it.
        if (count == 2'd2 && f_addr[rd_ptr] == sprite_RAM_addr)
            rd_data = f_data[rd_ptr];
        if (count != 2'd0 && f_addr[~wr_ptr] == sprite_RAM_addr)
            rd_data = f_data[~wr_ptr];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_addr <= '0;
            f_data <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                f_addr[wr_ptr] <= cpu_addr;
                f_data[wr_ptr] <= cpu_din;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // Unmapped drained entries are dropped without touching err_count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mem <= '0;
        else if (pop && dr_map[5])
            mem[dr_map[4:0]] <= f_data[rd_ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sprite_RAM_din <= 8'h00;
            addr_err       <= 1'b0;
            err_count      <= 8'h00;
        end else begin
            addr_err <= rd_en && !rd_map[5];
            if (rd_en) begin
                sprite_RAM_din <= rd_map[5] ? rd_data : 8'h00;
                if (!rd_map[5] && err_count != 8'hFF)
                    err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sprite_attr_ram.sv
// Scoreboard bench for sprite_attr_ram: directed scenarios then random traffic,
// checked against an address-keyed reference model with a queue-based write buffer.
module tb_sprite_attr_ram;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic [15:0] sprite_RAM_addr = '0;
    logic [7:0]  sprite_RAM_din;
    logic        addr_err;
    logic [7:0]  err_count;
    logic        cpu_wr_valid = 1'b0;
    logic        cpu_wr_ready;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_din = '0;

    sprite_attr_ram dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .sprite_RAM_addr(sprite_RAM_addr),
        .sprite_RAM_din(sprite_RAM_din), .addr_err(addr_err), .err_count(err_count),
        .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] addr; logic [7:0] data; } wr_t;
    typedef struct { logic [7:0] data; logic err; logic [7:0] cnt; logic [15:0] addr; } exp_t;

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: storage keyed directly by byte address, pending writes as a queue.
    logic [7:0] mm[int];
    wr_t        mq[$];
    exp_t       expq[$];
    int         errc = 0;
    logic [7:0] last_din = 8'h00;

    function automatic bit mapped(input logic [15:0] a);
        return (a >= 16'h4FF0 && a <= 16'h4FFF) || (a >= 16'h5060 && a <= 16'h506F);
    endfunction

    function automatic logic [7:0] lookup(input logic [15:0] a);
`ifdef SPRITE_RAM_BYPASS_EN
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].addr == a) return mq[i].data;
`endif
        return mm.exists(int'(a)) ? mm[int'(a)] : 8'h00;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mm.delete();
            mq.delete();
            expq.delete();
            errc     = 0;
            last_din = 8'h00;
        end else begin
            int   pre;
            exp_t e;
            wr_t  w;
            pre = mq.size();
            if (rd_en) begin
                e.addr = sprite_RAM_addr;
                e.err  = !mapped(sprite_RAM_addr);
                e.data = e.err ? 8'h00 : lookup(sprite_RAM_addr);
                if (e.err && errc < 255) errc++;
                e.cnt = 8'(errc);
                expq.push_back(e);
                last_din = e.data;
            end else if (pre > 0) begin
                w = mq.pop_front();
                if (mapped(w.addr)) mm[int'(w.addr)] = w.data;
            end
            if (cpu_wr_valid && pre < 2) begin
                w.addr = cpu_addr;
                w.data = cpu_din;
                mq.push_back(w);
            end
        end
    end

    // Monitor: compares DUT outputs mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            check("rst_din", sprite_RAM_din, 0);
            check("rst_addr_err", addr_err, 0);
            check("rst_err_count", err_count, 0);
            check("rst_ready", cpu_wr_ready, 1);
        end else begin
            if (expq.size() > 0) begin
                exp_t e;
                e = expq.pop_front();
                check($sformatf("rd_data@%04h", e.addr), sprite_RAM_din, e.data);
                check("addr_err", addr_err, e.err);
                check("err_count", err_count, e.cnt);
            end else begin
                check("no_err_idle", addr_err, 0);
                check("din_hold", sprite_RAM_din, last_din);
            end
            check("wr_ready", cpu_wr_ready, (mq.size() < 2) ? 1 : 0);
        end
    end

    // Stimulus: pending CPU writes are presented in order with a valid/ready handshake.
    wr_t wq[$];

    task automatic cyc(input logic rd, input logic [15:0] ra);
        logic rdy;
        rd_en           = rd;
        sprite_RAM_addr = ra;
        cpu_wr_valid    = (wq.size() > 0);
        if (wq.size() > 0) begin
            cpu_addr = wq[0].addr;
            cpu_din  = wq[0].data;
        end
        @(negedge clk);
        rdy = cpu_wr_ready;
        @(posedge clk);
        if (cpu_wr_valid && rdy) void'(wq.pop_front());
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wq.push_back(w);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        rd_en        = 1'b0;
        cpu_wr_valid = 1'b0;
        wq.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic logic [15:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 16'($urandom);
        else if (r < 5) return 16'h4FF0 + 16'($urandom_range(0, 15));
        else return 16'h5060 + 16'($urandom_range(0, 15));
    endfunction

    initial begin
        do_reset();
        // Fresh storage reads as zero everywhere.
        for (int i = 0; i < 16; i++) cyc(1'b1, 16'h4FF0 + 16'(i));
        for (int i = 0; i < 16; i++) cyc(1'b1, 16'h5060 + 16'(i));
        // Single write, two idle cycles, then read back.
        wr(16'h5062, 8'h7A);
        repeat (3) cyc(1'b0, 16'h0000);
        cyc(1'b1, 16'h5062);
        cyc(1'b0, 16'h0000);
        // Reads block drain; third write waits for rd_en to fall.
        wr(16'h4FF2, 8'h11); wr(16'h4FF3, 8'h22); wr(16'h5064, 8'h33);
        for (int i = 0; i < 10; i++) cyc(1'b1, 16'h4FF0 + 16'(i));
        repeat (4) cyc(1'b0, 16'h0000);
        cyc(1'b1, 16'h4FF2); cyc(1'b1, 16'h4FF3); cyc(1'b1, 16'h5064);
        // Unmapped reads and counter saturation.
        cyc(1'b1, 16'h1234); cyc(1'b1, 16'h1234); cyc(1'b0, 16'h0000);
        for (int i = 0; i < 300; i++) cyc(1'b1, 16'h1234);
        cyc(1'b1, 16'h1234); cyc(1'b0, 16'h0000);
        // Pending write vs stored value on the same byte.
        wr(16'h4FF1, 8'h05);
        repeat (3) cyc(1'b0, 16'h0000);
        wr(16'h4FF1, 8'h0C);
        cyc(1'b1, 16'h5060); cyc(1'b1, 16'h5060);
        cyc(1'b1, 16'h4FF1);
        repeat (3) cyc(1'b0, 16'h0000);
        cyc(1'b1, 16'h4FF1);
        // Reset with two pending entries discards them.
        wr(16'h4FF4, 8'hAA); wr(16'h5066, 8'hBB);
        cyc(1'b1, 16'h4FF0); cyc(1'b1, 16'h4FF0); cyc(1'b1, 16'h4FF0);
        do_reset();
        cyc(1'b1, 16'h4FF4); cyc(1'b1, 16'h5066); cyc(1'b0, 16'h0000);
        // Unmapped write is dropped silently.
        wr(16'h2000, 8'h99);
        repeat (2) cyc(1'b0, 16'h0000);
        cyc(1'b1, 16'h4FF0);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if (wq.size() < 3 && $urandom_range(0, 2) == 0)
                wr(rand_addr(), 8'($urandom));
            cyc(1'($urandom_range(0, 1)), rand_addr());
        end
        repeat (6) cyc(1'b0, 16'h0000);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/sprite_attr_ram.md
SPRITE_ATTR_RAM -- requirements
Module: sprite_attr_ram

Interface
REQ-001: clk  input  1  system clock; all state updates on rising edge.
REQ-002: rst  input  1  reset, asynchronous, active-high.
REQ-003: rd_en  input  1  video-side read strobe from the sprite fetch FSM.
REQ-004: sprite_RAM_addr  input  16  video-side read byte address.
REQ-005: sprite_RAM_din  output  8  read data returned to the fetch FSM, registered.
REQ-006: addr_err  output  1  one-cycle pulse, aligned with read data, flagging an unmapped read.
REQ-007: err_count  output  8  saturating count of unmapped reads.
REQ-008: cpu_wr_valid  input  1  CPU write request.
REQ-009: cpu_wr_ready  output  1  write buffer can accept a request.
REQ-010: cpu_addr  input  16  CPU write byte address.
REQ-011: cpu_din  input  8  CPU write data.

Function
REQ-012: Storage SHALL be 32 bytes in two regions: A = 0x4FF0-0x4FFF (even: sprite number/flips, odd: palette), mapped to index addr[3:0]; B = 0x5060-0x506F (even: X, odd: Y), mapped to index 16+addr[3:0].
REQ-013: Sprite n (0-7) SHALL occupy A at 0x4FF0+2n / 0x4FF1+2n and B at 0x5060+2n / 0x5061+2n.
REQ-014: Read latency SHALL be exactly 1 cycle: rd_en high at edge k -> sprite_RAM_din valid after edge k+1.
REQ-015: sprite_RAM_din SHALL hold its last value while rd_en is low.
REQ-016: Unmapped read SHALL return 0x00, pulse addr_err with the data, and increment err_count, which saturates at 0xFF.
REQ-017: CPU writes SHALL enter a 2-entry FIFO; a write is accepted when cpu_wr_valid && cpu_wr_ready.
REQ-018: cpu_wr_ready SHALL equal !full; accepting a write while a drain occurs in the same cycle on a full FIFO is not permitted (ready low).
REQ-019: The FIFO head SHALL drain into storage in any cycle with rd_en low: one entry per cycle, in order.
REQ-020: While rd_en is high, no drain SHALL occur; the video read always wins.
REQ-021: A drained entry with an unmapped address SHALL be discarded silently (no err_count change).
REQ-022: Same cycle, FIFO empty, valid write and rd_en low: the write SHALL be enqueued and drain on the next eligible cycle (minimum 1 cycle enqueue-to-storage).
REQ-023: Read of a byte with a pending FIFO write SHALL follow REQ-039/REQ-040.

Reset
REQ-024: On rst: all 32 storage bytes = 0x00.
REQ-025: On rst: FIFO empty and cpu_wr_ready = 1.
REQ-026: On rst: sprite_RAM_din = 0x00, addr_err = 0, err_count = 0x00.
REQ-027: Reset mid-drain or mid-read SHALL discard pending writes and in-flight read data.
REQ-028: The first read after reset deasserts SHALL return 0x00 from any mapped address.

Configuration
REQ-039: Macro SPRITE_RAM_BYPASS_EN defined: a read whose address matches a pending FIFO entry SHALL return the newest matching entry's data.
REQ-040: Macro SPRITE_RAM_BYPASS_EN undefined: a read SHALL return storage contents only (pre-write value).

Verification
REQ-041: Reset; read 0x4FF0..0x4FFF and 0x5060..0x506F -> all 0x00, addr_err never high, err_count = 0.
REQ-042: rd_en low; write 0x5062 = 0x7A; read 0x5062 after 2 idle cycles -> 0x7A exactly 1 cycle after rd_en.
REQ-043: Hold rd_en high for 10 cycles while CPU writes 3 times -> cpu_wr_ready drops after 2 accepts; the third write completes after rd_en falls; all 3 bytes readable.
REQ-044: Read 0x1234 twice -> data 0x00, addr_err pulses twice, err_count = 2; 300 unmapped reads -> err_count = 0xFF.
REQ-045: Write 0x4FF1 = 0x0C with storage 0x05 and hold rd_en to block drain; read 0x4FF1 -> 0x0C with BYPASS_EN, 0x05 without.
REQ-046: Assert rst while the FIFO holds 2 entries -> after release, both target bytes read 0x00 and cpu_wr_ready = 1.
